dsi_hs_lane_rx: RTL and testbench
=================================

DSI_HS_LANE_RX -- requirements
Module: dsi_hs_lane_rx

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of rx_enable-high cycles ignored before sync search (HS-settle/HS-zero).
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 8: maximum sync-search cycles before sync_err.
REQ-003 SHALL have parameter TRAIL_BYTES, default 2: aligned bytes held back and discarded at end of burst (HS-trail).
REQ-004 clk_sys  input  1  byte clock of the deserializer; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_enable  input  1  HS termination active (LP-to-HS detected); low means LP/stop state.
REQ-007 hs_input  input  8  raw unaligned deserialized byte; bit 0 is the earliest received bit.
REQ-008 data_out  output  8  aligned payload byte.
REQ-009 data_valid  output  1  data_out valid this cycle (one-cycle strobe per byte).
REQ-010 active  output  1  high from sync detect until burst end.
REQ-011 eot  output  1  one-cycle pulse at end of a burst that reached ACTIVE.
REQ-012 sync_err  output  1  one-cycle pulse when sync is not found within SYNC_TIMEOUT.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SYNC_SEARCH, ACTIVE, WAIT_END.
REQ-014 IDLE -> SETTLE when rx_enable=1; SETTLE -> SYNC_SEARCH after SETTLE_CYCLES cycles in SETTLE.
REQ-015 rx_enable=0 in SETTLE, SYNC_SEARCH or WAIT_END SHALL return the FSM to IDLE with no eot and no data.
REQ-016 SHALL keep prev_byte (hs_input of the previous cycle) and form window = {hs_input, prev_byte}, 16 bits.
REQ-017 In SYNC_SEARCH, SHALL test window[k+7:k] == 8'b00011101 for k = 0..7; the lowest matching k is latched as offset and the FSM moves to ACTIVE.
REQ-018 If rx_enable=0 in the same cycle as a sync match, rx_enable wins: FSM -> IDLE, no ACTIVE.
REQ-019 After SYNC_TIMEOUT search cycles without a match, SHALL pulse sync_err and enter WAIT_END until rx_enable=0.
REQ-020 In ACTIVE, each cycle with rx_enable=1 SHALL push window[offset+7:offset] into a TRAIL_BYTES-deep holdback FIFO.
REQ-021 A push into a full holdback SHALL pop the oldest entry to data_out with data_valid=1 in the following cycle.
REQ-022 Latency: byte aligned in window cycle t appears on data_out at cycle t+TRAIL_BYTES+1.
REQ-023 rx_enable=0 in ACTIVE SHALL discard holdback contents, pulse eot next cycle, clear active, and enter IDLE.
REQ-024 active SHALL be set in the cycle after the sync match and cleared with eot.
REQ-025 data_out SHALL hold its last value when data_valid=0.
REQ-026 offset SHALL be 3 bits; holdback occupancy counter SHALL saturate at TRAIL_BYTES.

Reset
REQ-027 On rst_n low: state IDLE; data_out=8'h00; data_valid, active, eot, sync_err = 0; prev_byte, offset, counters, holdback cleared.
REQ-028 Reset mid-ACTIVE SHALL drop all held bytes without eot; after release the block requires a fresh rx_enable rise and sync.

Structure
REQ-029 SYNC_SEQUENCE (8'b00011101) and the rx state enum SHALL live in shared package dsi_pkg, also used by the HS transmit lane.
REQ-030 Sync search and barrel shift SHALL be sub-module dsi_hs_byte_aligner (inputs window, outputs match, match_offset, aligned byte for a given offset).

Verification
REQ-031 Offset 0: rx_enable=1, hs_input 00,00,1D,A5,3C,7E,FF,FF then rx_enable=0 -> data_out A5,3C,7E with data_valid; eot one pulse; no FF bytes out.
REQ-032 Offset 3: same bit stream shifted 3 bits later -> offset=3, identical output A5,3C,7E and one eot.
REQ-033 No sync: rx_enable=1, hs_input 00 for 12 cycles -> sync_err exactly once, no data_valid, no eot, active stays 0.
REQ-034 rx_enable drops during SETTLE and in the cycle of sync match -> IDLE, no data_valid, eot or sync_err.
REQ-035 rst_n asserted after 2 payload bytes in ACTIVE -> all outputs 0 immediately; next burst with payload 55 yields only 55.
REQ-036 Back-to-back bursts separated by one rx_enable-low cycle -> each burst decoded independently, one eot per burst.

Source files
------------

// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI high-speed lane blocks (receive and transmit).
package dsi_pkg;

   // Leader byte that opens every HS burst, bit 0 sent first.
   localparam logic [7:0] SYNC_SEQUENCE = 8'b0001_1101;

   // Receive-lane protocol states.
   typedef enum logic [2:0] {
      RX_IDLE        = 3'd0,
      RX_SETTLE      = 3'd1,
      RX_SYNC_SEARCH = 3'd2,
      RX_ACTIVE      = 3'd3,
      RX_WAIT_END    = 3'd4
   } rx_state_e;

   // Byte starting at bit position 'offset' inside a two-byte window.
   function automatic logic [7:0] window_byte(input logic [15:0] window, input logic [2:0] offset);
      return window[offset +: 8];
   endfunction

endpackage

// File: rtl/dsi_hs_lane_rx_if.sv
// Byte-level connection between the HS deserializer/PHY side and the lane receiver.
interface dsi_hs_lane_rx_if;
   logic       rx_enable;
   logic [7:0] hs_input;
   logic [7:0] data_out;
   logic       data_valid;
   logic       active;
   logic       eot;
   logic       sync_err;

   modport master (
      output rx_enable, hs_input,
      input  data_out, data_valid, active, eot, sync_err
   );

   modport slave (
      input  rx_enable, hs_input,
      output data_out, data_valid, active, eot, sync_err
   );
endinterface

// File: rtl/dsi_hs_byte_aligner.sv
// Sync-pattern search over a 16-bit window and barrel shift for a chosen bit offset.
module dsi_hs_byte_aligner
   import dsi_pkg::*;
(
   input  logic [15:0] window,
   input  logic [2:0]  offset,
   output logic        match,
   output logic [2:0]  match_offset,
   output logic [7:0]  aligned_byte
);

   logic [7:0] hit_s;

   // Compare each of the eight byte-wide slices of the window with the sync pattern.
   always_comb begin
      hit_s = 8'h00;
      for (int k = 0; k < 8; k++) begin
         hit_s[k] = (window[k +: 8] == SYNC_SEQUENCE);
      end
   end

   // Priority-encode the hits so that the lowest matching bit position wins.
   always_comb begin
      match        = 1'b1;
      match_offset = 3'd0;
      casez (hit_s)
         8'b???????1: match_offset = 3'd0;
         8'b??????10: match_offset = 3'd1;
         8'b?????100: match_offset = 3'd2;
         8'b????1000: match_offset = 3'd3;
         8'b???10000: match_offset = 3'd4;
         8'b??100000: match_offset = 3'd5;
         8'b?1000000: match_offset = 3'd6;
         8'b10000000: match_offset = 3'd7;
         default: begin
            match        = 1'b0;
            match_offset = 3'd0;
         end
      endcase
   end

   // Extract the byte that starts at the locked bit offset.
   always_comb begin
      aligned_byte = window_byte(window, offset);
   end

endmodule

// File: rtl/dsi_hs_lane_rx.sv
// DSI high-speed data lane receiver: settle, sync search, byte alignment and
// HS-trail removal through a small holdback buffer.
module dsi_hs_lane_rx
   import dsi_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int SYNC_TIMEOUT  = 8,
   parameter int TRAIL_BYTES   = 2
)(
   input  logic            clk_sys,
   input  logic            rst_n,
   dsi_hs_lane_rx_if.slave lane
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SYNC_TIMEOUT) ? SETTLE_CYCLES : SYNC_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int HW      = $clog2(TRAIL_BYTES + 1);

   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] SEARCH_LAST = CW'(SYNC_TIMEOUT - 1);
   localparam logic [HW-1:0] HB_ZERO     = {HW{1'b0}};
   localparam logic [HW-1:0] HB_ONE      = HW'(1);
   localparam logic [HW-1:0] HB_FULL     = HW'(TRAIL_BYTES);

   rx_state_e        state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [2:0]       offset_r, offset_s;
   logic [7:0]       prev_byte_r;
   logic [15:0]      window_s;
   logic             match_s;
   logic [2:0]       match_offset_s;
   logic [7:0]       aligned_s;

   logic             push_s, flush_s, pop_s;
   logic             eot_s, err_s, active_s;
   logic             hb_full_s;
   logic [HW-1:0]    hb_cnt_r, hb_cnt_s;
   logic [7:0]       hb_mem_r [TRAIL_BYTES];
   logic [7:0]       hb_mem_s [TRAIL_BYTES];

   logic [7:0]       data_out_r;
   logic             data_valid_r, active_r, eot_r, sync_err_r;

   // Current byte on top of the previous one: any 8-bit alignment is visible here.
   always_comb begin
      window_s = {lane.hs_input, prev_byte_r};
   end

   dsi_hs_byte_aligner u_aligner (
      .window       (window_s),
      .offset       (offset_r),
      .match        (match_s),
      .match_offset (match_offset_s),
      .aligned_byte (aligned_s)
   );

   // State register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RX_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; rx_enable low always dominates any other event.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      offset_s = offset_r;
      push_s   = 1'b0;
      flush_s  = 1'b0;
      eot_s    = 1'b0;
      err_s    = 1'b0;
      active_s = active_r;
      case (state_r)
         RX_IDLE: begin
            if (lane.rx_enable) begin
               state_s = RX_SETTLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = RX_IDLE;
            end
         end
         RX_SETTLE: begin
            if (!lane.rx_enable) begin
               state_s = RX_IDLE;
            end else if (cnt_r == SETTLE_LAST) begin
               state_s = RX_SYNC_SEARCH;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         RX_SYNC_SEARCH: begin
            if (!lane.rx_enable) begin
               state_s = RX_IDLE;
            end else if (match_s) begin
               state_s  = RX_ACTIVE;
               offset_s = match_offset_s;
               active_s = 1'b1;
            end else if (cnt_r == SEARCH_LAST) begin
               state_s = RX_WAIT_END;
               err_s   = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         RX_ACTIVE: begin
            if (!lane.rx_enable) begin
               state_s  = RX_IDLE;
               flush_s  = 1'b1;
               eot_s    = 1'b1;
               active_s = 1'b0;
            end else begin
               push_s   = 1'b1;
            end
         end
         RX_WAIT_END: begin
            if (!lane.rx_enable) begin
               state_s = RX_IDLE;
            end else begin
               state_s = RX_WAIT_END;
            end
         end
         default: begin
            state_s  = RX_IDLE;
            flush_s  = 1'b1;
            active_s = 1'b0;
         end
      endcase
   end

   // Holdback: the newest TRAIL_BYTES bytes stay inside until more payload proves
   // they are not HS-trail; a push into a full buffer releases the oldest byte.
   always_comb begin
      hb_mem_s  = hb_mem_r;
      hb_cnt_s  = hb_cnt_r;
      pop_s     = 1'b0;
      hb_full_s = (hb_cnt_r == HB_FULL);
      if (flush_s) begin
         for (int i = 0; i < TRAIL_BYTES; i++) begin
            hb_mem_s[i] = 8'h00;
         end
         hb_cnt_s = HB_ZERO;
      end else if (push_s) begin
         if (hb_full_s) begin
            pop_s = 1'b1;
            for (int i = 0; i < TRAIL_BYTES - 1; i++) begin
               hb_mem_s[i] = hb_mem_r[i + 1];
            end
            hb_mem_s[TRAIL_BYTES - 1] = aligned_s;
         end else begin
            for (int i = 0; i < TRAIL_BYTES; i++) begin
               if (HW'(i) == hb_cnt_r) begin
                  hb_mem_s[i] = aligned_s;
               end else begin
                  hb_mem_s[i] = hb_mem_r[i];
               end
            end
            hb_cnt_s = hb_cnt_r + HB_ONE;
         end
      end else begin
         hb_cnt_s = hb_cnt_r;
      end
   end

   // Datapath and output registers; data_out keeps its value between strobes.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         prev_byte_r  <= 8'h00;
         cnt_r        <= CNT_ZERO;
         offset_r     <= 3'd0;
         hb_cnt_r     <= HB_ZERO;
         for (int i = 0; i < TRAIL_BYTES; i++) begin
            hb_mem_r[i] <= 8'h00;
         end
         data_out_r   <= 8'h00;
         data_valid_r <= 1'b0;
         active_r     <= 1'b0;
         eot_r        <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         prev_byte_r  <= lane.hs_input;
         cnt_r        <= cnt_s;
         offset_r     <= offset_s;
         hb_cnt_r     <= hb_cnt_s;
         hb_mem_r     <= hb_mem_s;
         data_out_r   <= pop_s ? hb_mem_r[0] : data_out_r;
         data_valid_r <= pop_s;
         active_r     <= active_s;
         eot_r        <= eot_s;
         sync_err_r   <= err_s;
      end
   end

   assign lane.data_out   = data_out_r;
   assign lane.data_valid = data_valid_r;
   assign lane.active     = active_r;
   assign lane.eot        = eot_r;
   assign lane.sync_err   = sync_err_r;

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// Self-checking bench for dsi_hs_lane_rx: table of bursts plus hand-written
// back-to-back and reset-in-burst sequences, payload bytes checked by scoreboard.
module tb_dsi_hs_lane_rx;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;

   always #5 clk_sys = ~clk_sys;

   dsi_hs_lane_rx_if lane ();

   dsi_hs_lane_rx #(
      .SETTLE_CYCLES (2),
      .SYNC_TIMEOUT  (8),
      .TRAIL_BYTES   (2)
   ) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .lane    (lane)
   );

   // One burst: bytes driven with rx_enable high, then rx_enable drops.
   typedef struct packed {
      logic [0:15][7:0] stim;
      logic [4:0]       n_stim;
      logic [0:3][7:0]  exp_b;
      logic [2:0]       n_exp;
      logic [2:0]       exp_off;
      logic [1:0]       n_eot;
      logic [1:0]       n_err;
      logic [3:0]       n_act;
   } vec_t;

   localparam int NV = 7;
   vec_t  tbl   [NV];
   string names [NV];

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q [$];
   int         eot_cnt, err_cnt, act_cnt, first_valid, burst_i;
   logic [7:0] last_out = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      eot_cnt     = 0;
      err_cnt     = 0;
      act_cnt     = 0;
      first_valid = -1;
      exp_q.delete();
   endtask

   // Observe outputs of the current cycle (called on the falling edge).
   task automatic sample(input int i);
      if (lane.data_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious byte: got %0h at cycle %0d, expected no data_valid", lane.data_out, i);
         end else begin
            check("data_out", lane.data_out, exp_q.pop_front());
         end
         if (first_valid < 0) first_valid = i;
         last_out = lane.data_out;
      end else begin
         check("data_out hold", lane.data_out, last_out);
      end
      if (lane.eot) begin
         eot_cnt++;
         check("active low with eot", lane.active, 0);
      end
      if (lane.sync_err) err_cnt++;
      if (lane.active) act_cnt++;
   endtask

   task automatic drive_bytes(input logic [0:15][7:0] s, input int n, input logic chk_off, input logic [2:0] off);
      burst_i = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         sample(burst_i);
         if (chk_off && burst_i == 4) check("locked offset", dut.offset_r, off);
         burst_i++;
         lane.rx_enable = 1'b1;
         lane.hs_input  = s[i];
      end
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         sample(burst_i);
         burst_i++;
         lane.rx_enable = 1'b0;
         lane.hs_input  = 8'h00;
      end
   endtask

   task automatic run_vec(input int t);
      vec_t v;
      v = tbl[t];
      clear_stats();
      for (int j = 0; j < 4; j++) begin
         if (j < int'(v.n_exp)) exp_q.push_back(v.exp_b[j]);
      end
      drive_bytes(v.stim, int'(v.n_stim), v.n_act != 4'd0, v.exp_off);
      drive_idle(6);
      check({names[t], " eot count"},      eot_cnt, v.n_eot);
      check({names[t], " sync_err count"}, err_cnt, v.n_err);
      check({names[t], " active cycles"},  act_cnt, v.n_act);
      check({names[t], " first valid cycle"}, first_valid, (v.n_exp != 3'd0) ? 7 : -1);
      check({names[t], " bytes missing"},  exp_q.size(), 0);
   endtask

   initial begin
      // The last trail byte is only aligned once it has moved into the previous-byte
      // half of the window, so every burst carries one extra filler byte after it.
      tbl[0] = '{stim: {8'h00,8'h00,8'h1D,8'hA5,8'h3C,8'h7E,8'hFF,8'hFF,8'h00,{7{8'h00}}},
                 n_stim: 5'd9, exp_b: {8'hA5,8'h3C,8'h7E,8'h00}, n_exp: 3'd3, exp_off: 3'd0,
                 n_eot: 2'd1, n_err: 2'd0, n_act: 4'd6};
      names[0] = "offset0";
      // Same bit stream delayed by three bits.
      tbl[1] = '{stim: {8'h00,8'h00,8'hE8,8'h28,8'hE5,8'hF1,8'hFB,8'hFF,8'h07,{7{8'h00}}},
                 n_stim: 5'd9, exp_b: {8'hA5,8'h3C,8'h7E,8'h00}, n_exp: 3'd3, exp_off: 3'd3,
                 n_eot: 2'd1, n_err: 2'd0, n_act: 4'd6};
      names[1] = "offset3";
      // Payload 5A,C3 delayed by seven bits.
      tbl[2] = '{stim: {8'h00,8'h00,8'h80,8'h0E,8'hAD,8'h61,8'h00,8'h00,{8{8'h00}}},
                 n_stim: 5'd8, exp_b: {8'h5A,8'hC3,8'h00,8'h00}, n_exp: 3'd2, exp_off: 3'd7,
                 n_eot: 2'd1, n_err: 2'd0, n_act: 4'd5};
      names[2] = "offset7";
      // Only two bytes after sync: both are trail, nothing comes out.
      tbl[3] = '{stim: {8'h00,8'h00,8'h1D,8'h11,8'h22,8'h00,{10{8'h00}}},
                 n_stim: 5'd6, exp_b: 32'h0, n_exp: 3'd0, exp_off: 3'd0,
                 n_eot: 2'd1, n_err: 2'd0, n_act: 4'd3};
      names[3] = "trail_only";
      tbl[4] = '{stim: {16{8'h00}}, n_stim: 5'd12, exp_b: 32'h0, n_exp: 3'd0, exp_off: 3'd0,
                 n_eot: 2'd0, n_err: 2'd1, n_act: 4'd0};
      names[4] = "no_sync";
      tbl[5] = '{stim: {8'h00,8'h1D,{14{8'h00}}}, n_stim: 5'd2, exp_b: 32'h0, n_exp: 3'd0,
                 exp_off: 3'd0, n_eot: 2'd0, n_err: 2'd0, n_act: 4'd0};
      names[5] = "drop_in_settle";
      // rx_enable falls in exactly the cycle the window shows the sync byte.
      tbl[6] = '{stim: {8'h00,8'h00,8'h1D,{13{8'h00}}}, n_stim: 5'd3, exp_b: 32'h0, n_exp: 3'd0,
                 exp_off: 3'd0, n_eot: 2'd0, n_err: 2'd0, n_act: 4'd0};
      names[6] = "drop_at_match";

      lane.rx_enable = 1'b0;
      lane.hs_input  = 8'h00;
      #1;
      check("reset data_out",   lane.data_out,   8'h00);
      check("reset data_valid", lane.data_valid, 1'b0);
      check("reset active",     lane.active,     1'b0);
      check("reset eot",        lane.eot,        1'b0);
      check("reset sync_err",   lane.sync_err,   1'b0);
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;

      for (int t = 0; t < NV; t++) run_vec(t);

      // Two bursts separated by a single rx_enable-low cycle.
      clear_stats();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'h55);
      drive_bytes(tbl[0].stim, 9, 1'b1, 3'd0);
      drive_idle(1);
      drive_bytes({8'h00,8'h00,8'h1D,8'h55,8'h00,8'h00,8'h00,{9{8'h00}}}, 7, 1'b1, 3'd0);
      drive_idle(6);
      check("b2b eot count",      eot_cnt, 2);
      check("b2b sync_err count", err_cnt, 0);
      check("b2b active cycles",  act_cnt, 10);
      check("b2b bytes missing",  exp_q.size(), 0);

      // Reset while two payload bytes sit in the holdback.
      clear_stats();
      drive_bytes({8'h00,8'h00,8'h1D,8'h11,8'h22,8'h33,{10{8'h00}}}, 6, 1'b1, 3'd0);
      @(negedge clk_sys);
      check("active before reset", lane.active, 1'b1);
      rst_n          = 1'b0;
      lane.rx_enable = 1'b0;
      lane.hs_input  = 8'h00;
      #1;
      check("mid reset data_out",   lane.data_out,   8'h00);
      check("mid reset data_valid", lane.data_valid, 1'b0);
      check("mid reset active",     lane.active,     1'b0);
      check("mid reset eot",        lane.eot,        1'b0);
      check("mid reset sync_err",   lane.sync_err,   1'b0);
      @(negedge clk_sys);
      rst_n    = 1'b1;
      last_out = 8'h00;
      clear_stats();
      exp_q.push_back(8'h55);
      drive_bytes({8'h00,8'h00,8'h1D,8'h55,8'h00,8'h00,8'h00,{9{8'h00}}}, 7, 1'b1, 3'd0);
      drive_idle(6);
      check("post reset eot count",      eot_cnt, 1);
      check("post reset sync_err count", err_cnt, 0);
      check("post reset bytes missing",  exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
